ps2_keyboard_rx: RTL and testbench
==================================

PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: number of consecutive equal synchronized PS2C samples needed to change the filtered clock.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000: MCLK cycles without a filtered PS2C falling edge before a partial frame is abandoned.
REQ-003 SHALL have port MCLK, input, 1: sole clock, rising-edge active.
REQ-004 SHALL have port reset_n, input, 1: synchronous active-low reset, sampled on MCLK rising edge.
REQ-005 SHALL have port PS2C, input, 1: asynchronous keyboard clock line.
REQ-006 SHALL have port PS2D, input, 1: asynchronous keyboard data line.
REQ-007 SHALL have port scan_code, output, 8: last accepted byte, held until the next accept.
REQ-008 SHALL have port scan_valid, output, 1: one-cycle pulse when scan_code is updated.
REQ-009 SHALL have port key_break, output, 1: valid with scan_valid; byte was preceded by an F0 prefix.
REQ-010 SHALL have port key_ext, output, 1: valid with scan_valid; byte was preceded by an E0 prefix.
REQ-011 SHALL have port frame_err, output, 1: one-cycle pulse on a start-bit, parity, stop-bit or timeout error.

Function
REQ-012 SHALL pass PS2C and PS2D through two-flop synchronizers before any other use.
REQ-013 SHALL change the filtered clock only after FILTER_LEN consecutive equal synchronized PS2C samples; shorter glitches are ignored.
REQ-014 SHALL flag a falling edge in the single cycle the filtered clock goes 1->0, sampling synchronized PS2D in that same cycle.
REQ-015 SHALL implement FSM states IDLE, DATA, PARITY, STOP; transitions occur only on falling-edge cycles, except on timeout.
REQ-016 IDLE: sampled 0 -> DATA with bit counter 0; sampled 1 -> stay IDLE with frame_err pulse.
REQ-017 DATA: shift the sample in LSB-first; after the 8th bit -> PARITY.
REQ-018 PARITY: store the sample -> STOP; parity is odd over 8 data bits plus parity bit.
REQ-019 STOP: sample 1 with correct parity -> accept byte; otherwise frame_err pulse, no accept; always -> IDLE.
REQ-020 An accept SHALL assert its output pulse in the cycle after the stop-bit falling-edge cycle.
REQ-021 SHALL count MCLK cycles since the last falling edge while not in IDLE; reaching TIMEOUT_CYCLES -> IDLE with one frame_err pulse, discarding partial data.
REQ-022 scan_valid and frame_err SHALL never be asserted in the same cycle.
REQ-023 A falling edge in the same cycle the timeout fires SHALL be ignored; the next edge is treated as a start bit.

Reset
REQ-024 While reset_n is low at a clock edge: FSM -> IDLE; bit counter, timeout counter and prefix flags cleared; scan_code=8'h00; scan_valid, key_break, key_ext, frame_err = 0.
REQ-025 Synchronizer and filter state SHALL reset to 1 (idle-high line), so release of reset produces no falling edge.
REQ-026 Reset mid-frame SHALL discard the partial frame with no frame_err pulse.

Configuration
REQ-027 Macro PS2_PREFIX_DECODE_EN defined: bytes E0/F0 are not reported; they set pending ext/break flags, which are output with the next non-prefix byte and then cleared; any frame_err clears both pending flags.
REQ-028 PS2_PREFIX_DECODE_EN undefined: every accepted byte, including E0/F0, is reported via scan_valid; key_break and key_ext are tied to 0.

Verification
REQ-029 Valid frame of byte 8'h1C, 40 us bit period -> scan_code=8'h1C, exactly one scan_valid pulse, frame_err never asserted.
REQ-030 Macro defined, frames E0, F0, 75 -> exactly one scan_valid pulse, scan_code=8'h75, key_break=1, key_ext=1; next frame 1C -> key_break=0, key_ext=0.
REQ-031 Frame 8'h1C with parity bit inverted -> one frame_err pulse, no scan_valid, scan_code unchanged.
REQ-032 Start bit plus 5 data bits, then idle for TIMEOUT_CYCLES -> one frame_err pulse; following valid frame 8'h29 -> scan_code=8'h29.
REQ-033 PS2C low glitch of FILTER_LEN-2 cycles mid-bit in a valid 8'h1C frame -> scan_code=8'h1C, no frame_err.
REQ-034 reset_n held low 2 cycles after the 4th data bit, then valid frame 8'h5A -> no frame_err, scan_code=8'h5A.

Source files
------------

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes and de-glitches PS2C, deframes 11-bit frames.
// Define PS2_PREFIX_DECODE_EN to fold E0/F0 prefixes into key_ext/key_break.
module ps2_keyboard_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       MCLK,
    input  logic       reset_n,
    input  logic       PS2C,
    input  logic       PS2D,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       key_break,
    output logic       key_ext,
    output logic       frame_err
);

    localparam int unsigned FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic              ps2c_s1_q, ps2c_s2_q;
    logic              ps2d_s1_q, ps2d_s2_q;
    logic              ps2c_filt_q, ps2c_filt_d;
    logic              ps2c_prev_q;
    logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
    logic              fall_c;
    logic              timeout_c;

    logic [1:0]        state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_q, par_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [7:0]        code_q, code_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
`ifdef PS2_PREFIX_DECODE_EN
    logic              pend_brk_q, pend_brk_d;
    logic              pend_ext_q, pend_ext_d;
    logic              brk_q, brk_d;
    logic              ext_q, ext_d;
`endif

    // Filtered clock flips only after FILTER_LEN consecutive differing samples
    always_comb begin
        ps2c_filt_d = ps2c_filt_q;
        filt_cnt_d  = '0;
        if (ps2c_s2_q != ps2c_filt_q) begin
            if (filt_cnt_q == FILT_W'(FILTER_LEN - 1)) begin
                ps2c_filt_d = ps2c_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FILT_W'(1);
            end
        end
    end

    assign fall_c    = ps2c_prev_q & ~ps2c_filt_q;
    assign timeout_c = (state_q != S_IDLE) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Frame FSM; timeout wins over a coincident falling edge
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        to_cnt_d  = to_cnt_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
`ifdef PS2_PREFIX_DECODE_EN
        pend_brk_d = pend_brk_q;
        pend_ext_d = pend_ext_q;
        brk_d      = brk_q;
        ext_d      = ext_q;
`endif

        if (state_q == S_IDLE || fall_c) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        if (timeout_c) begin
            state_d  = S_IDLE;
            err_d    = 1'b1;
            to_cnt_d = '0;
        end else if (fall_c) begin
            case (state_q)
                S_IDLE: begin
                    if (!ps2d_s2_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_DATA: begin
                    shift_d   = {ps2d_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    par_d   = ps2d_s2_q;
                    state_d = S_STOP;
                end
                default: begin
                    state_d = S_IDLE;
                    if (ps2d_s2_q && (^{shift_q, par_q})) begin
`ifdef PS2_PREFIX_DECODE_EN
                        if (shift_q == 8'hE0) begin
                            pend_ext_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            pend_brk_d = 1'b1;
                        end else begin
                            code_d     = shift_q;
                            valid_d    = 1'b1;
                            brk_d      = pend_brk_q;
                            ext_d      = pend_ext_q;
                            pend_brk_d = 1'b0;
                            pend_ext_d = 1'b0;
                        end
`else
                        code_d  = shift_q;
                        valid_d = 1'b1;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end

`ifdef PS2_PREFIX_DECODE_EN
        if (err_d) begin
            pend_brk_d = 1'b0;
            pend_ext_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge MCLK) begin
        if (!reset_n) begin
            ps2c_s1_q   <= 1'b1;
            ps2c_s2_q   <= 1'b1;
            ps2d_s1_q   <= 1'b1;
            ps2d_s2_q   <= 1'b1;
            ps2c_filt_q <= 1'b1;
            ps2c_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            to_cnt_q    <= '0;
            code_q      <= 8'h00;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
`ifdef PS2_PREFIX_DECODE_EN
            pend_brk_q  <= 1'b0;
            pend_ext_q  <= 1'b0;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
`endif
        end else begin
            ps2c_s1_q   <= PS2C;
            ps2c_s2_q   <= ps2c_s1_q;
            ps2d_s1_q   <= PS2D;
            ps2d_s2_q   <= ps2d_s1_q;
            ps2c_filt_q <= ps2c_filt_d;
            ps2c_prev_q <= ps2c_filt_q;
            filt_cnt_q  <= filt_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            to_cnt_q    <= to_cnt_d;
            code_q      <= code_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
`ifdef PS2_PREFIX_DECODE_EN
            pend_brk_q  <= pend_brk_d;
            pend_ext_q  <= pend_ext_d;
            brk_q       <= brk_d;
            ext_q       <= ext_d;
`endif
        end
    end

    assign scan_code  = code_q;
    assign scan_valid = valid_q;
    assign frame_err  = err_q;
`ifdef PS2_PREFIX_DECODE_EN
    assign key_break  = brk_q;
    assign key_ext    = ext_q;
`else
    assign key_break  = 1'b0;
    assign key_ext    = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: frame-level expectation queue checked every cycle,
// plus literal checks per scenario. Honours PS2_PREFIX_DECODE_EN like the DUT.
module tb_ps2_keyboard_rx;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 2000;
    localparam int HALF           = 40;

    logic       MCLK = 1'b0;
    logic       reset_n = 1'b0;
    logic       PS2C = 1'b1;
    logic       PS2D = 1'b1;
    logic [7:0] scan_code;
    logic       scan_valid, key_break, key_ext, frame_err;

    ps2_keyboard_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .MCLK      (MCLK),
        .reset_n   (reset_n),
        .PS2C      (PS2C),
        .PS2D      (PS2D),
        .scan_code (scan_code),
        .scan_valid(scan_valid),
        .key_break (key_break),
        .key_ext   (key_ext),
        .frame_err (frame_err)
    );

    always #5 MCLK = ~MCLK;

    typedef struct packed {
        logic       err;
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } exp_t;

    exp_t       exp_q[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    int         n_valid  = 0;
    int         n_err    = 0;
    logic [7:0] m_code   = 8'h00;
    logic       m_pbrk   = 1'b0;
    logic       m_pext   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par);
        logic par;
        par = ~(^b) ^ bad_par;
        return {1'b1, par, b, 1'b0};
    endfunction

    // Frame-level model of what the receiver must report for one frame
    task automatic expect_frame(input logic [7:0] b, input bit ok);
        exp_t e;
        e.err = 1'b0; e.code = b; e.brk = 1'b0; e.ext = 1'b0;
        if (!ok) begin
            e.err = 1'b1;
            m_pbrk = 1'b0;
            m_pext = 1'b0;
            exp_q.push_back(e);
            return;
        end
`ifdef PS2_PREFIX_DECODE_EN
        if (b == 8'hE0) begin m_pext = 1'b1; return; end
        if (b == 8'hF0) begin m_pbrk = 1'b1; return; end
        e.brk = m_pbrk;
        e.ext = m_pext;
        m_pbrk = 1'b0;
        m_pext = 1'b0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge MCLK);
    endtask

    task automatic send_bits(input logic [10:0] f, input int n, input int glitch_bit);
        for (int i = 0; i < n; i++) begin
            PS2D = f[i];
            if (i == glitch_bit) begin
                wait_cycles(HALF / 2);
                PS2C = 1'b0;
                wait_cycles(FILTER_LEN - 2);
                PS2C = 1'b1;
                wait_cycles(HALF - HALF / 2 - (FILTER_LEN - 2));
            end else begin
                wait_cycles(HALF);
            end
            PS2C = 1'b0;
            wait_cycles(HALF);
            PS2C = 1'b1;
        end
        wait_cycles(HALF);
        PS2D = 1'b1;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge MCLK);
            n++;
        end
        chk(name, exp_q.size(), 0);
        wait_cycles(FILTER_LEN + 2 * HALF);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int glitch_bit);
        expect_frame(b, !bad_par);
        send_bits(make_frame(b, bad_par), 11, glitch_bit);
        wait_drain(FILTER_LEN + 100, "frame_drain");
    endtask

    // Per-cycle compare against the expectation queue
    initial begin : compare
        exp_t e;
        forever begin
            @(posedge MCLK);
            #1;
            if (!reset_n) begin
                m_code = 8'h00;
                exp_q.delete();
                chk("reset_outputs", {20'h0, scan_code, scan_valid, frame_err, key_break, key_ext}, 32'h0);
                continue;
            end
            chk("valid_err_exclusive", 32'(scan_valid & frame_err), 32'h0);
            if (scan_valid || frame_err) begin
                if (scan_valid) n_valid++;
                if (frame_err) n_err++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {30'h0, scan_valid, frame_err}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", {30'h0, scan_valid, frame_err}, e.err ? 32'h1 : 32'h2);
                    if (!e.err) begin
                        chk("scan_code", 32'(scan_code), 32'(e.code));
                        chk("key_break", 32'(key_break), 32'(e.brk));
                        chk("key_ext", 32'(key_ext), 32'(e.ext));
                        m_code = e.code;
                    end
                end
            end else begin
                chk("scan_code_hold", 32'(scan_code), 32'(m_code));
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : driver
        int v0, e0;
        wait_cycles(4);
        chk("reset_scan_code", 32'(scan_code), 32'h00);
        chk("reset_scan_valid", 32'(scan_valid), 32'h0);
        reset_n = 1'b1;
        wait_cycles(20);

        // Plain valid frame
        v0 = n_valid; e0 = n_err;
        send_frame(8'h1C, 1'b0, -1);
        chk("s1_code", 32'(scan_code), 32'h1C);
        chk("s1_valid_count", 32'(n_valid - v0), 32'd1);
        chk("s1_err_count", 32'(n_err - e0), 32'd0);

        // Prefix sequence E0 F0 75 then 1C
        v0 = n_valid;
        send_frame(8'hE0, 1'b0, -1);
        send_frame(8'hF0, 1'b0, -1);
        send_frame(8'h75, 1'b0, -1);
        chk("s2_code", 32'(scan_code), 32'h75);
`ifdef PS2_PREFIX_DECODE_EN
        chk("s2_valid_count", 32'(n_valid - v0), 32'd1);
        chk("s2_break", 32'(key_break), 32'h1);
        chk("s2_ext", 32'(key_ext), 32'h1);
`else
        chk("s2_valid_count", 32'(n_valid - v0), 32'd3);
        chk("s2_break", 32'(key_break), 32'h0);
        chk("s2_ext", 32'(key_ext), 32'h0);
`endif
        send_frame(8'h1C, 1'b0, -1);
        chk("s2b_break", 32'(key_break), 32'h0);
        chk("s2b_ext", 32'(key_ext), 32'h0);

        // Parity error on a known byte after a different stored byte
        send_frame(8'h29, 1'b0, -1);
        v0 = n_valid; e0 = n_err;
        send_frame(8'h1C, 1'b1, -1);
        chk("s3_err_count", 32'(n_err - e0), 32'd1);
        chk("s3_valid_count", 32'(n_valid - v0), 32'd0);
        chk("s3_code_unchanged", 32'(scan_code), 32'h29);

        // Partial frame then timeout, followed by a good frame
        e0 = n_err;
        expect_frame(8'h00, 1'b0 == 1'b1);
        send_bits(make_frame(8'h4B, 1'b0), 6, -1);
        wait_drain(TIMEOUT_CYCLES + 200, "s4_timeout_drain");
        chk("s4_err_count", 32'(n_err - e0), 32'd1);
        send_frame(8'h29, 1'b0, -1);
        chk("s4_code", 32'(scan_code), 32'h29);

        // Short PS2C glitch mid-bit is filtered out
        e0 = n_err;
        send_frame(8'h1C, 1'b0, 3);
        chk("s5_code", 32'(scan_code), 32'h1C);
        chk("s5_err_count", 32'(n_err - e0), 32'd0);

        // Reset mid-frame after the 4th data bit
        e0 = n_err;
        send_bits(make_frame(8'h33, 1'b0), 5, -1);
        reset_n = 1'b0;
        m_pbrk  = 1'b0;
        m_pext  = 1'b0;
        wait_cycles(2);
        reset_n = 1'b1;
        wait_cycles(4);
        chk("s6_code_after_reset", 32'(scan_code), 32'h00);
        send_frame(8'h5A, 1'b0, -1);
        chk("s6_code", 32'(scan_code), 32'h5A);
        chk("s6_err_count", 32'(n_err - e0), 32'd0);

        wait_cycles(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
